// File: rtl/pc_ras_pkg.sv
// rtl/pc_ras_pkg.sv - shared widths and next-PC select encoding for pc_ras
package pc_ras_pkg;

  // Default PC/address width and signed branch displacement width
  localparam int DEF_PC_W   = 16;
  localparam int DEF_DISP_W = 8;

  // Source of the next PC value
  typedef enum logic [1:0] {
    SEL_INC = 2'd0,  // pc + 1
    SEL_BR  = 2'd1,  // pc + sext(disp)
    SEL_DST = 2'd2,  // dDst (jump, call, ret on empty stack)
    SEL_TOP = 2'd3   // return-stack top
  } pc_sel_e;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - circular return-address stack with overwrite-oldest on overflow
module ras_lifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             swap,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp;
  logic [PW-1:0]    tp_inc;
  logic [PW-1:0]    tp_dec;
  logic [PW:0]      cnt;

  assign tp_inc = tp + 1'b1;
  assign tp_dec = tp - 1'b1;
  assign top    = mem[tp];
  assign empty  = (cnt == '0);
  assign full   = (cnt == (PW+1)'(DEPTH));
  // A push on a full stack silently replaces the oldest entry; flag it
  assign ovf    = push & full;
  assign unf    = pop & empty;

  // Pointer, count and entry updates; swap rewrites the top in place
  always_ff @(posedge clk) begin
    if (rst) begin
      tp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (swap && !empty) begin
      mem[tp] <= din;
    end else if (push) begin
      // When full, tp+1 lands on the oldest slot, so the write overwrites it
      tp          <= tp_inc;
      mem[tp_inc] <= din;
      if (!full) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      tp  <= tp_dec;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - fetch program counter with next-PC priority mux and return-address stack
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              DISP_W    = DEF_DISP_W,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcEn,
  input  logic              branch,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [DISP_W-1:0] disp,
  input  logic [PC_W-1:0]   dDst,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_ra,
  output logic [PC_W-1:0]   pc_next,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  pc_sel_e         sel;
  logic [PC_W-1:0] disp_sext;
  logic [PC_W-1:0] ras_top;
  logic            st_push;
  logic            st_pop;
  logic            st_swap;
  logic            st_ovf;
  logic            st_unf;

  assign pc_ra     = pc + 1'b1;
  assign disp_sext = {{(PC_W-DISP_W){disp[DISP_W-1]}}, disp};

  // call+ret on a live stack swaps the top; on an empty stack it degrades to a plain call
  assign st_swap = pcEn & call & ret & ~ras_empty;
  assign st_push = pcEn & call & ~(ret & ~ras_empty);
  assign st_pop  = pcEn & ret & ~call;

  // Request priority: ret > call > jump > branch > increment
  always_comb begin
    sel = SEL_INC;
    if (ret && !ras_empty)       sel = SEL_TOP;
    else if (ret || call || jump) sel = SEL_DST;
    else if (branch)              sel = SEL_BR;
    case (sel)
      SEL_BR:  pc_next = pc + disp_sext;
      SEL_DST: pc_next = dDst;
      SEL_TOP: pc_next = ras_top;
      default: pc_next = pc_ra;
    endcase
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (pcEn) pc <= pc_next;
  end

  // Sticky stack error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                   ras_err <= 1'b0;
    else if (st_ovf || st_unf) ras_err <= 1'b1;
  end

  ras_lifo #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_W)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (st_push),
    .pop   (st_pop),
    .swap  (st_swap),
    .din   (pc_ra),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full),
    .ovf   (st_ovf),
    .unf   (st_unf)
  );

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program counter with an integrated return-address stack (RAS); successor to the single-register `pc` block. It sits in the fetch stage of the ASIC core. It supplies the fetch address and the link value, and it resolves branch, jump, call and return requests from decode. Call/return nesting is handled in hardware, up to RAS_DEPTH levels, with defined overflow and underflow behaviour.

## Interface
- PC_W, 16, PC and address width
- DISP_W, 8 (= `IMMWIDTH), branch displacement width, signed
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2
- RESET_PC, 16'h0000, PC value after reset
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pcEn  in  1  PC/stack update enable; 0 = hold everything
- branch  in  1  PC-relative branch request
- jump  in  1  absolute jump to dDst
- call  in  1  absolute jump to dDst and push return address
- ret  in  1  pop return address into PC
- disp  in  DISP_W  signed branch displacement
- dDst  in  PC_W  absolute target; also the fallback target for ret on an empty stack
- pc  out  PC_W  current PC (registered)
- pc_ra  out  PC_W  pc+1 mod 2^PC_W (combinational; link value)
- pc_next  out  PC_W  value pc will take at the next enabled edge (combinational)
- ras_empty  out  1  stack count == 0
- ras_full  out  1  stack count == RAS_DEPTH
- ras_err  out  1  sticky flag; set on overflow or underflow, cleared only by rst

## Operation
- Reset values: pc=RESET_PC, pc_ra=RESET_PC+1, stack count=0, all entries=0, ras_empty=1, ras_full=0, ras_err=0.
- pcEn=0: pc, stack and ras_err hold. pc_next still reflects the decoded request.
- Request priority when pcEn=1: ret > call > jump > branch > increment.
- Increment: pc ← pc+1.
- branch: pc ← pc + sext(disp). The target is relative to the current pc, not to pc+1.
- jump: pc ← dDst.
- call: pc ← dDst; push pc+1.
- ret with stack non-empty: pc ← top; pop.
- ret with stack empty: pc ← dDst; count stays 0; ras_err ← 1.
- call with stack full: overwrite the oldest entry (circular buffer); count stays RAS_DEPTH; ras_err ← 1.
- call and ret together, stack non-empty: pc ← top; top overwritten with pc+1; count unchanged (coroutine swap).
- call and ret together, stack empty: treated as a plain call.
- Arithmetic: all additions are modulo 2^PC_W, so wrap-around is silent. ffff+1=0000, and 0000+sext(8'h80)=ff80.
- The stack is a circular buffer: top pointer of log2(RAS_DEPTH) bits plus a count of log2(RAS_DEPTH)+1 bits.

## Timing
- Single-cycle: a request sampled at posedge N is visible on pc after posedge N.
- pc_ra and pc_next are combinational from pc, the stack top and the request inputs; there is no registered latency.
- ras_empty and ras_full derive from the registered count, so they update in the same edge as the push or pop.
- rst dominates pcEn and every request. Reset asserted mid-call-chain discards all stack contents in that edge.
- Inputs must be stable a setup time before posedge. There is no handshake; decode guarantees one request vector per enabled cycle.

## Structure
- In shared defines.v: `IMMWIDTH (default for DISP_W), and `PCW, a 16-bit default used by the top-level instantiation.
- Sub-module `ras_lifo`:
  - Parameters: depth and width.
  - Ports: push, pop, swap, din, top, empty, full, ovf, unf.
  - Handles pointer wrap and the overwrite-oldest rule.
- `pc_ras` holds the PC register, the next-PC mux and priority, and the sticky ras_err.

## Test plan
- Reset then 3 enabled idle cycles → pc 0000→0001→0002→0003; pc_ra = pc+1 each cycle.
- Starting at pc=0001:
  - branch disp=7f → pc=0080.
  - Then branch disp=81 → pc=0001.
  - Then pcEn=0 for 2 cycles → pc holds at 0001.
- Nested calls:
  - At pc=0010, call dDst=0100, then call dDst=0200 → stack holds {0011, 0101}.
  - ret → pc=0101; ret → pc=0011; ras_empty=1; ras_err=0.
- Overflow with RAS_DEPTH=4:
  - 5 calls pushing return addresses A1..A5 → ras_full=1, ras_err=1.
  - 4 rets → pc=A5, A4, A3, A2, then ras_empty=1.
- Underflow: ret on an empty stack with dDst=8000 → pc=8000, ras_err=1, count=0. A later reset → ras_err=0.
- Edge cases:
  - pc=ffff, increment → pc=0000.
  - call and ret together with top=1234 at pc=0050 → pc=1234, new top=0051.
  - rst asserted mid-stack → pc=RESET_PC, ras_empty=1.
